// File: rtl/src_ctrl_sequencer.sv
// Control-step sequencer for the Mini SRC datapath: fetch T0-T2, decode at T3,
// then a per-class execute sequence, with a memory-ready stall and a retire counter.
module src_ctrl_sequencer #(
    parameter int               OPC_W       = 5,
    parameter int               ALU_W       = 5,
    parameter logic [ALU_W-1:0] ALU_ADD     = 5'b00001,
    parameter logic [ALU_W-1:0] ALU_SUB     = 5'b00010,
    parameter logic [ALU_W-1:0] ALU_AND     = 5'b00011,
    parameter logic [ALU_W-1:0] ALU_OR      = 5'b00100,
    parameter int               MEM_HS      = 1,
    parameter int               MEM_TIMEOUT = 15,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             mem_rdy,
    output logic             pc_out,
    output logic             mar_en,
    output logic             pc_inc,
    output logic             read,
    output logic             write,
    output logic             mdr_en,
    output logic             mdr_out,
    output logic             ir_en,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             r_in,
    output logic             r_out,
    output logic             ba_out,
    output logic             c_out,
    output logic             y_en,
    output logic             z_en,
    output logic             zlo_out,
    output logic [ALU_W-1:0] alu_control,
    output logic [3:0]       step,
    output logic             busy,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    // State encoding doubles as the step code seen on the step output.
    typedef enum logic [3:0] {
        S_T0   = 4'h0,
        S_T1   = 4'h1,
        S_T2   = 4'h2,
        S_T3   = 4'h3,
        S_T4   = 4'h4,
        S_T5   = 4'h5,
        S_T6   = 4'h6,
        S_T7   = 4'h7,
        S_HALT = 4'hE,
        S_IDLE = 4'hF
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_RALU = 3'd1,
        C_IALU = 3'd2,
        C_LDI  = 3'd3,
        C_LD   = 3'd4,
        C_ST   = 3'd5
    } cls_t;

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(26);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(27);

    localparam int               TO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t           state, next_state;
    cls_t             cls_q, dec_cls;
    logic [ALU_W-1:0] alu_q, dec_alu;
    logic [TO_W-1:0]  wait_cnt;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q, mem_err_q;
    logic             dec_nop, dec_halt, dec_ill;
    logic             mem_step, mem_wait, timeout;
    logic             eoi, set_ill, set_err;
    logic [OPC_W-1:0] opc;
    logic             unused_ir;

    assign opc       = ir[31 -: OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];

    always_comb begin
        dec_cls  = C_NONE;
        dec_alu  = '0;
        dec_nop  = 1'b0;
        dec_halt = 1'b0;
        dec_ill  = 1'b0;
        case (opc)
            OP_LD:   begin dec_cls = C_LD;   dec_alu = ALU_ADD; end
            OP_LDI:  begin dec_cls = C_LDI;  dec_alu = ALU_ADD; end
            OP_ST:   begin dec_cls = C_ST;   dec_alu = ALU_ADD; end
            OP_ADD:  begin dec_cls = C_RALU; dec_alu = ALU_ADD; end
            OP_SUB:  begin dec_cls = C_RALU; dec_alu = ALU_SUB; end
            OP_AND:  begin dec_cls = C_RALU; dec_alu = ALU_AND; end
            OP_OR:   begin dec_cls = C_RALU; dec_alu = ALU_OR;  end
            OP_ADDI: begin dec_cls = C_IALU; dec_alu = ALU_ADD; end
            OP_ANDI: begin dec_cls = C_IALU; dec_alu = ALU_AND; end
            OP_ORI:  begin dec_cls = C_IALU; dec_alu = ALU_OR;  end
            OP_NOP:  dec_nop  = 1'b1;
            OP_HALT: dec_halt = 1'b1;
            default: dec_ill  = 1'b1;
        endcase
    end

    // Memory handshake: a read/write step holds its controls until mem_rdy is
    // sampled high at a rising edge; mem_rdy high on entry gives a one-cycle step.
    assign mem_step = (state == S_T1) ||
                      (state == S_T6 && cls_q == C_LD) ||
                      (state == S_T7 && cls_q == C_ST);
    assign mem_wait = (MEM_HS != 0) && mem_step && !mem_rdy;
    assign timeout  = mem_wait && (wait_cnt == TO_LAST);

    always_comb begin
        next_state = state;
        eoi        = 1'b0;
        set_ill    = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: if (run) next_state = S_T0;
            S_T0:   next_state = S_T1;
            S_T1:   next_state = S_T2;
            S_T2:   next_state = S_T3;
            S_T3: begin
                if (dec_nop) begin
                    eoi = 1'b1;
                end else if (dec_halt) begin
                    next_state = S_HALT;
                end else if (dec_ill) begin
                    set_ill    = 1'b1;
                    next_state = S_HALT;
                end else begin
                    next_state = S_T4;
                end
            end
            S_T4:   next_state = S_T5;
            S_T5: begin
                if (cls_q == C_LD || cls_q == C_ST) next_state = S_T6;
                else eoi = 1'b1;
            end
            S_T6:   next_state = S_T7;
            S_T7:   eoi = 1'b1;
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
        if (eoi) next_state = run ? S_T0 : S_IDLE;
        // A stall overrides the normal advance, including the end of a store.
        if (mem_wait) begin
            eoi = 1'b0;
            if (timeout) begin
                set_err    = 1'b1;
                next_state = S_HALT;
            end else begin
                next_state = state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= S_IDLE;
            cls_q     <= C_NONE;
            alu_q     <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_T3) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
            end
            wait_cnt <= (mem_wait && !timeout) ? wait_cnt + TO_W'(1) : '0;
            if (eoi)     retired_q <= retired_q + CNT_W'(1);
            if (set_ill) illegal_q <= 1'b1;
            if (set_err) mem_err_q <= 1'b1;
        end
    end

    // Moore outputs; T3 follows the opcode already held in ir.
    always_comb begin
        pc_out      = 1'b0;
        mar_en      = 1'b0;
        pc_inc      = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        mdr_en      = 1'b0;
        mdr_out     = 1'b0;
        ir_en       = 1'b0;
        gra         = 1'b0;
        grb         = 1'b0;
        grc         = 1'b0;
        r_in        = 1'b0;
        r_out       = 1'b0;
        ba_out      = 1'b0;
        c_out       = 1'b0;
        y_en        = 1'b0;
        z_en        = 1'b0;
        zlo_out     = 1'b0;
        alu_control = '0;
        case (state)
            S_T0: begin pc_out = 1'b1; mar_en = 1'b1; pc_inc = 1'b1; end
            S_T1: begin read = 1'b1; mdr_en = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_en = 1'b1; end
            S_T3: begin
                if (dec_cls == C_RALU || dec_cls == C_IALU) begin
                    grb = 1'b1; r_out = 1'b1; y_en = 1'b1;
                end else if (dec_cls != C_NONE) begin
                    grb = 1'b1; ba_out = 1'b1; y_en = 1'b1;
                end
            end
            S_T4: begin
                z_en        = 1'b1;
                alu_control = alu_q;
                if (cls_q == C_RALU) begin
                    grc = 1'b1; r_out = 1'b1;
                end else begin
                    c_out = 1'b1;
                end
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (cls_q == C_LD || cls_q == C_ST) begin
                    mar_en = 1'b1;
                end else begin
                    gra = 1'b1; r_in = 1'b1;
                end
            end
            S_T6: begin
                mdr_en = 1'b1;
                if (cls_q == C_ST) begin
                    gra = 1'b1; r_out = 1'b1;
                end else begin
                    read = 1'b1;
                end
            end
            S_T7: begin
                if (cls_q == C_ST) begin
                    write = 1'b1;
                end else begin
                    mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign step    = state;
    assign busy    = ~state[3];
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;
    assign retired = retired_q;

endmodule
